// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test engine: the Galois
// polynomial, FSM state encodings and the single-step shift function.
package alu_bist_pkg;

    // x^32 + x^22 + x^2 + x + 1, feedback taps in Galois form
    localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

    // Wide enough for NUM_VECTORS-1 with NUM_VECTORS up to 2^16
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_e;

    function automatic logic [31:0] galois_step(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/alu_bist_lfsr32.sv
// 32-bit Galois shift register with synchronous seed load and a parallel
// input folded into every step, so one block serves as generator or MISR.
module alu_bist_lfsr32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        en_i,
    input  logic [31:0] din_i,
    output logic [31:0] q_o
);
    import alu_bist_pkg::*;

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Load wins over stepping so a restart never absorbs a stale vector
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (en_i) begin
            state_d = galois_step(state_q) ^ din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= 32'h0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q_o = state_q;

endmodule

// File: rtl/alu_bist.sv
// ALU self-test engine: drives LFSR operands and a cycling opcode into the
// ALU and compacts its result and flags into a 32-bit MISR signature.
module alu_bist #(
    parameter int          NUM_VECTORS = 1024,
    parameter int          OP_COUNT    = 16,
    parameter logic [31:0] SEED_A      = 32'h0000_0001,
    parameter logic [31:0] SEED_B      = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] expected_sig_i,
    output logic [31:0] alu_srcA_o,
    output logic [31:0] alu_srcB_o,
    output logic [4:0]  alu_op_o,
    input  logic [31:0] alu_out_i,
    input  logic        alu_zero_i,
    input  logic        alu_ovf_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] signature_o
);
    import alu_bist_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VECTORS - 1);
    localparam logic [4:0]       OP_LAST  = 5'(OP_COUNT - 1);

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic             pass_q, pass_d;

    logic        enter_run;
    logic        gen_step;
    logic        misr_en;
    logic        last_vec;
    logic [31:0] misr_din;
    logic [31:0] misr_nxt;

    assign last_vec = (cnt_q == CNT_LAST);
    assign misr_din = alu_out_i ^ {30'b0, alu_zero_i, alu_ovf_i};
    // Value the MISR takes at this edge, needed for the pass verdict
    assign misr_nxt = galois_step(signature_o) ^ misr_din;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        pass_d    = pass_q;
        enter_run = 1'b0;
        gen_step  = 1'b0;
        misr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                enter_run = start_i;
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    misr_en = 1'b1;
                    if (last_vec) begin
                        // Operands freeze on the final vector
                        state_d = ST_DONE;
                        pass_d  = (misr_nxt == expected_sig_i);
                    end else begin
                        gen_step = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                        op_d     = (op_q == OP_LAST) ? 5'd0 : op_q + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    enter_run = start_i;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_run) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            op_d    = 5'd0;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 5'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            pass_q  <= pass_d;
        end
    end

    alu_bist_lfsr32 u_gen_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (enter_run),
        .seed_i (SEED_A),
        .en_i   (gen_step),
        .din_i  (32'h0),
        .q_o    (alu_srcA_o)
    );

    alu_bist_lfsr32 u_gen_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (enter_run),
        .seed_i (SEED_B),
        .en_i   (gen_step),
        .din_i  (32'h0),
        .q_o    (alu_srcB_o)
    );

    // The MISR register is the signature itself; cleared on every run start
    alu_bist_lfsr32 u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (enter_run),
        .seed_i (32'h0),
        .en_i   (misr_en),
        .din_i  (misr_din),
        .q_o    (signature_o)
    );

    assign alu_op_o = op_q;
    assign busy_o   = (state_q == ST_RUN);
    assign done_o   = (state_q == ST_DONE);
    assign pass_o   = pass_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a behavioural ALU and a vector-list model of the BIST
// run, plus directed runs on small instances with hand-computed values.
module tb_alu_bist;

    localparam int          NV    = 1024;
    localparam int          OPC   = 16;
    localparam logic [31:0] POLY  = 32'h0040_0007;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (default parameters) with a behavioural ALU
    logic        m_start = 1'b0, m_abort = 1'b0, fault = 1'b0;
    logic [31:0] exp_sig = 32'h0;
    logic [31:0] a_srcA, a_srcB, a_out, a_sig;
    logic [4:0]  a_op;
    logic        a_zero, a_ovf, a_busy, a_done, a_pass;

    // small instances driven by a constant ALU stub (out=0, zero=1, ovf=0)
    logic        s_start = 1'b0, s_abort = 1'b0;
    logic [31:0] exp3 = 32'h0000_000E, exp2 = 32'h0000_0006;
    logic [31:0] t3_srcA, t3_srcB, t3_sig, t2_srcA, t2_srcB, t2_sig;
    logic [4:0]  t3_op, t2_op;
    logic        t3_busy, t3_done, t3_pass, t2_busy, t2_done, t2_pass;

    int nvec = 0, nbad = 0;

    function automatic logic [31:0] lfsr_fn(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] misr_fn(input logic [31:0] s, input logic [33:0] r);
        return lfsr_fn(s) ^ r[33:2] ^ {30'b0, r[1], r[0]};
    endfunction

    // {out, zero, ovf}; the fault pins result bit 0 low
    function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op, input logic flt);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            5'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            5'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = ~(a | b);
            5'd6: r = a << b[4:0];
            5'd7: r = a >> b[4:0];
            5'd8: r = $unsigned($signed(a) >>> b[4:0]);
            5'd9: r = {31'b0, $signed(a) < $signed(b)};
            5'd10: r = {31'b0, a < b};
            5'd11: r = {b[15:0], 16'h0};
            default: r = a + 32'(op);
        endcase
        return {(flt ? {r[31:1], 1'b0} : r), (r == 32'h0), v};
    endfunction

    assign {a_out, a_zero, a_ovf} = alu_fn(a_srcA, a_srcB, a_op, fault);

    alu_bist u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(m_start), .abort_i(m_abort),
        .expected_sig_i(exp_sig), .alu_srcA_o(a_srcA), .alu_srcB_o(a_srcB),
        .alu_op_o(a_op), .alu_out_i(a_out), .alu_zero_i(a_zero), .alu_ovf_i(a_ovf),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .signature_o(a_sig)
    );

    alu_bist #(.NUM_VECTORS(3)) u_n3 (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .abort_i(s_abort),
        .expected_sig_i(exp3), .alu_srcA_o(t3_srcA), .alu_srcB_o(t3_srcB),
        .alu_op_o(t3_op), .alu_out_i(32'h0), .alu_zero_i(1'b1), .alu_ovf_i(1'b0),
        .busy_o(t3_busy), .done_o(t3_done), .pass_o(t3_pass), .signature_o(t3_sig)
    );

    alu_bist #(.NUM_VECTORS(2)) u_n2 (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .abort_i(s_abort),
        .expected_sig_i(exp2), .alu_srcA_o(t2_srcA), .alu_srcB_o(t2_srcB),
        .alu_op_o(t2_op), .alu_out_i(32'h0), .alu_zero_i(1'b1), .alu_ovf_i(1'b0),
        .busy_o(t2_busy), .done_o(t2_done), .pass_o(t2_pass), .signature_o(t2_sig)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the run is the precomputed vector list, walked one entry per cycle
    logic [31:0] vecA [NV];
    logic [31:0] vecB [NV];
    logic [31:0] gold = 32'h0;
    int          m_ph = 0;     // 0 idle, 1 run, 2 done
    int          m_k  = 0;
    logic [31:0] ea = 32'h0, eb = 32'h0, esig = 32'h0;
    logic [4:0]  eop = 5'd0;
    logic        epass = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_k <= 0; ea <= 32'h0; eb <= 32'h0; eop <= 5'd0;
            esig <= 32'h0; epass <= 1'b0;
        end else begin
            case (m_ph)
                1: begin
                    if (m_abort) begin
                        m_ph <= 0; epass <= 1'b0;
                    end else begin
                        esig <= misr_fn(esig, alu_fn(ea, eb, eop, fault));
                        if (m_k == NV - 1) begin
                            m_ph  <= 2;
                            epass <= (misr_fn(esig, alu_fn(ea, eb, eop, fault)) == exp_sig);
                        end else begin
                            m_k <= m_k + 1;
                            ea  <= vecA[m_k + 1];
                            eb  <= vecB[m_k + 1];
                            eop <= 5'((m_k + 1) % OPC);
                        end
                    end
                end
                default: begin
                    if (m_ph == 2 && m_abort) begin
                        m_ph <= 0; epass <= 1'b0;
                    end else if (m_start) begin
                        m_ph <= 1; m_k <= 0; ea <= vecA[0]; eb <= vecB[0];
                        eop <= 5'd0; esig <= 32'h0; epass <= 1'b0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("srcA", a_srcA, ea);
        chk("srcB", a_srcB, eb);
        chk("op", {27'b0, a_op}, {27'b0, eop});
        chk("signature", a_sig, esig);
        chk("pass", {31'b0, a_pass}, {31'b0, epass});
        chk("busy", {31'b0, a_busy}, {31'b0, m_ph == 1});
        chk("done", {31'b0, a_done}, {31'b0, m_ph == 2});
    end

    int          cyc;
    logic [4:0]  op15, op16;
    logic [31:0] sig1;

    // Pulse (or hold) start on the main instance and count edges until done
    task automatic run_main(input bit hold);
        @(negedge clk); m_start = 1'b1;
        @(negedge clk); if (!hold) m_start = 1'b0;
        cyc = 0;
        while (a_done !== 1'b1 && cyc < NV + 20) begin
            if (cyc == 15) op15 = a_op;
            if (cyc == 16) op16 = a_op;
            @(negedge clk);
            cyc++;
        end
        m_start = 1'b0;
        chk("run_length", cyc, NV);
    endtask

    initial begin
        vecA[0] = 32'h0000_0001;
        vecB[0] = 32'h8000_0000;
        for (int k = 1; k < NV; k++) begin
            vecA[k] = lfsr_fn(vecA[k-1]);
            vecB[k] = lfsr_fn(vecB[k-1]);
        end
        for (int k = 0; k < NV; k++) gold = misr_fn(gold, alu_fn(vecA[k], vecB[k], 5'(k % OPC), 1'b0));
        exp_sig = gold;

        // model pins
        chk("model_A2", vecA[2], 32'h0000_0004);
        chk("model_B1", vecB[1], 32'h0040_0007);
        chk("model_misr", misr_fn(misr_fn(32'h0, {32'h0, 2'b10}), {32'h0, 2'b10}), 32'h0000_0006);

        #3;
        chk("rst_srcA", a_srcA, 32'h0);
        chk("rst_sig", a_sig, 32'h0);
        chk("rst_flags", {29'b0, a_busy, a_done, a_pass}, 32'h0);
        #19 rst_n = 1'b1;

        // N=3 trace and N=2 stub signature
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        chk("n3_A0", t3_srcA, 32'h0000_0001);
        chk("n3_B0", t3_srcB, 32'h8000_0000);
        chk("n3_op0", {27'b0, t3_op}, 32'd0);
        chk("n3_busy", {31'b0, t3_busy}, 32'd1);
        @(negedge clk);
        chk("n3_A1", t3_srcA, 32'h0000_0002);
        chk("n3_B1", t3_srcB, 32'h0040_0007);
        chk("n3_op1", {27'b0, t3_op}, 32'd1);
        @(negedge clk);
        chk("n3_A2", t3_srcA, 32'h0000_0004);
        chk("n3_op2", {27'b0, t3_op}, 32'd2);
        chk("n3_done_early", {31'b0, t3_done}, 32'd0);
        chk("n2_done", {31'b0, t2_done}, 32'd1);
        chk("n2_sig", t2_sig, 32'h0000_0006);
        chk("n2_pass6", {31'b0, t2_pass}, 32'd1);
        chk("n2_frozen", {t2_srcA[15:0], t2_srcB[31:16]}, 32'h0002_0040);
        chk("n2_op_frozen", {27'b0, t2_op}, 32'd1);
        chk("n2_busy", {31'b0, t2_busy}, 32'd0);
        @(negedge clk);
        chk("n3_done", {31'b0, t3_done}, 32'd1);
        chk("n3_sig", t3_sig, 32'h0000_000E);
        chk("n3_pass", {31'b0, t3_pass}, 32'd1);
        chk("n3_A_frozen", t3_srcA, 32'h0000_0004);
        exp2 = 32'h0000_0005;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("n2_pass5", {31'b0, t2_pass}, 32'd0);
        chk("n2_sig_rerun", t2_sig, 32'h0000_0006);

        // back-to-back full runs
        run_main(1'b0);
        chk("run1_sig", a_sig, gold);
        chk("run1_pass", {31'b0, a_pass}, 32'd1);
        sig1 = a_sig;
        run_main(1'b0);
        chk("run2_same", a_sig, sig1);

        // stuck-at-0 on result bit 0
        fault = 1'b1;
        run_main(1'b0);
        nvec++;
        if (a_sig === gold) begin
            nbad++;
            $display("FAIL fault_sig: got %h, expected a value other than %h", a_sig, gold);
        end
        chk("fault_pass", {31'b0, a_pass}, 32'd0);
        fault = 1'b0;

        // abort at vector 10, then a clean rerun
        @(negedge clk); m_start = 1'b1;
        @(negedge clk); m_start = 1'b0;
        repeat (10) @(negedge clk);
        m_abort = 1'b1;
        @(negedge clk); m_abort = 1'b0;
        chk("abort_busy", {31'b0, a_busy}, 32'd0);
        chk("abort_done", {31'b0, a_done}, 32'd0);
        run_main(1'b0);
        chk("after_abort_sig", a_sig, gold);

        // start held through RUN; op wraps 15 -> 0
        run_main(1'b1);
        chk("op_at15", {27'b0, op15}, 32'd15);
        chk("op_at16", {27'b0, op16}, 32'd0);
        chk("held_sig", a_sig, gold);

        // asynchronous reset mid-cycle at vector 500
        @(negedge clk); m_start = 1'b1;
        @(negedge clk); m_start = 1'b0;
        repeat (500) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ops", a_srcA | a_srcB | {27'b0, a_op}, 32'h0);
        chk("rst_mid_sig", a_sig, 32'h0);
        chk("rst_mid_flags", {29'b0, a_busy, a_done, a_pass}, 32'h0);
        chk("rst_mid_small", t3_sig | t2_sig | {30'b0, t3_done, t2_done}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {30'b0, a_busy, a_done}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
